// File: rtl/toggle_event_decoder.sv
// -----------------------------------------------------------------------------
// toggle_event_decoder
//
// Receive end of a toggle-encoded event link. The far end flips q_in once per
// event. This block synchronises that level into the ck domain, detects each
// level change and turns it back into one event. Each event is delivered in
// two ways: as a registered one-cycle pulse, and as a buffered count of
// pending events drained through a valid/ready handshake.
//
// Handshake: ev_valid is high whenever pending != 0. One event is accepted on
// every posedge ck where ev_valid and ev_ready are both high. ev_ready while
// ev_valid is low has no effect.
//
// Ports
//   ck        in   clock; all state updates on posedge ck
//   rs        in   synchronous active-high reset, overrides every other input
//   q_in      in   toggle-encoded event level (asynchronous to ck)
//   ev_ready  in   consumer accepts one pending event this cycle
//   clr_ovf   in   clears the sticky overflow flag
//   ev_pulse  out  one-cycle pulse per decoded event
//   ev_valid  out  high while pending != 0
//   pending   out  number of events not yet accepted (saturates at all ones)
//   ev_count  out  total decoded events, wraps silently
//   overflow  out  sticky: an event was lost because pending was full
// -----------------------------------------------------------------------------
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int PEND_W      = 4
) (
    input  logic              ck,
    input  logic              rs,
    input  logic              q_in,
    input  logic              ev_ready,
    input  logic              clr_ovf,
    output logic              ev_pulse,
    output logic              ev_valid,
    output logic [PEND_W-1:0] pending,
    output logic [CNT_W-1:0]  ev_count,
    output logic              overflow
);

    // FILL lasts SYNC_STAGES+1 cycles: long enough for the synchroniser to
    // hold the post-reset q_in level and for q_prev to adopt it as baseline.
    localparam int FILL_W = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SYNC_STAGES);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                   state_q,    state_d;
    logic [FILL_W-1:0]        fill_cnt_q, fill_cnt_d;
    logic [SYNC_STAGES-1:0]   sync_q,     sync_d;
    logic                     q_prev_q,   q_prev_d;
    logic                     ev_pulse_q, ev_pulse_d;
    logic [PEND_W-1:0]        pending_q,  pending_d;
    logic [CNT_W-1:0]         ev_count_q, ev_count_d;
    logic                     overflow_q, overflow_d;

    logic sync_last;
    logic toggle;
    logic accept;
    logic pend_full;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign toggle    = (state_q == RUN) && (sync_last ^ q_prev_q);
    assign accept    = (pending_q != '0) && ev_ready;
    assign pend_full = (pending_q == '1);

    always_ff @(posedge ck) begin
        if (rs) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
            sync_q     <= '0;
            q_prev_q   <= 1'b0;
            ev_pulse_q <= 1'b0;
            pending_q  <= '0;
            ev_count_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            sync_q     <= sync_d;
            q_prev_q   <= q_prev_d;
            ev_pulse_q <= ev_pulse_d;
            pending_q  <= pending_d;
            ev_count_q <= ev_count_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        sync_d     = {sync_q[SYNC_STAGES-2:0], q_in};
        q_prev_d   = sync_last;
        ev_pulse_d = toggle;
        pending_d  = pending_q;
        ev_count_d = ev_count_q;
        overflow_d = overflow_q;

        case (state_q)
            FILL: begin
                if (fill_cnt_q == FILL_LAST) begin
                    state_d = RUN;
                end else begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = FILL;
            end
        endcase

        if (toggle) begin
            ev_count_d = ev_count_q + 1'b1;
        end

        if (clr_ovf) begin
            overflow_d = 1'b0;
        end

        // Simultaneous event and accept cancel out. A lost event sets
        // overflow after the clear so it wins over clr_ovf.
        case ({toggle, accept})
            2'b10: begin
                if (pend_full) begin
                    overflow_d = 1'b1;
                end else begin
                    pending_d = pending_q + 1'b1;
                end
            end
            2'b01:   pending_d = pending_q - 1'b1;
            default: pending_d = pending_q;
        endcase
    end

    assign ev_pulse = ev_pulse_q;
    assign ev_valid = (pending_q != '0);
    assign pending  = pending_q;
    assign ev_count = ev_count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_toggle_event_decoder
//
// Directed bench for toggle_event_decoder with default parameters
// (SYNC_STAGES=2, CNT_W=8, PEND_W=4). Inputs change 1 time unit after a
// posedge and outputs are sampled at the same point, after the edge settles.
// -----------------------------------------------------------------------------
module tb_toggle_event_decoder;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;
    localparam int PEND_W      = 4;

    logic              ck;
    logic              rs;
    logic              q_in;
    logic              ev_ready;
    logic              clr_ovf;
    logic              ev_pulse;
    logic              ev_valid;
    logic [PEND_W-1:0] pending;
    logic [CNT_W-1:0]  ev_count;
    logic              overflow;

    int n_checks;
    int n_passed;
    logic seen;

    toggle_event_decoder #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W),
        .PEND_W     (PEND_W)
    ) dut (
        .ck      (ck),
        .rs      (rs),
        .q_in    (q_in),
        .ev_ready(ev_ready),
        .clr_ovf (clr_ovf),
        .ev_pulse(ev_pulse),
        .ev_valid(ev_valid),
        .pending (pending),
        .ev_count(ev_count),
        .overflow(overflow)
    );

    // Clock and safety timeout
    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running, required done");
        $fatal(1, "timeout");
    end

    // Advance n posedges, ending 1 unit after the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ck);
            #1;
        end
    endtask

    // Advance n posedges and report whether ev_pulse was seen high.
    task automatic watch(input int n, output logic saw);
        saw = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge ck);
            #1;
            saw = saw | ev_pulse;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Reset for n cycles, then let FILL complete.
    task automatic do_reset(input int n);
        rs = 1'b1;
        step(n);
        rs = 1'b0;
        step(SYNC_STAGES + 2);
    endtask

    // One event: flip q_in, then wait 4 cycles (event registered on the 3rd).
    task automatic flip_event();
        q_in = ~q_in;
        step(4);
    endtask

    initial begin
        n_checks = 0;
        n_passed = 0;
        rs       = 1'b1;
        q_in     = 1'b1;
        ev_ready = 1'b0;
        clr_ovf  = 1'b0;

        // T1: reset with q_in high; no event after release
        step(3);
        chk("t1_rst_pulse",    32'(ev_pulse), 32'd0);
        chk("t1_rst_valid",    32'(ev_valid), 32'd0);
        chk("t1_rst_pending",  32'(pending),  32'd0);
        chk("t1_rst_count",    32'(ev_count), 32'd0);
        chk("t1_rst_overflow", 32'(overflow), 32'd0);
        rs = 1'b0;
        watch(20, seen);
        chk("t1_no_pulse", 32'(seen),     32'd0);
        chk("t1_count",    32'(ev_count), 32'd0);
        chk("t1_pending",  32'(pending),  32'd0);

        // T2: rising q_in from a low baseline, exact pulse timing
        q_in = 1'b0;
        do_reset(1);
        q_in = 1'b1;
        step(1);
        chk("t2_pulse_k",   32'(ev_pulse), 32'd0);
        step(1);
        chk("t2_pulse_k1",  32'(ev_pulse), 32'd0);
        step(1);
        chk("t2_pulse_k2",  32'(ev_pulse), 32'd1);
        chk("t2_pending",   32'(pending),  32'd1);
        chk("t2_valid",     32'(ev_valid), 32'd1);
        chk("t2_count",     32'(ev_count), 32'd1);
        step(1);
        chk("t2_pulse_k3",  32'(ev_pulse), 32'd0);
        ev_ready = 1'b1;
        step(1);
        chk("t2_acc_pending", 32'(pending),  32'd0);
        chk("t2_acc_valid",   32'(ev_valid), 32'd0);
        step(1);
        ev_ready = 1'b0;
        chk("t2_ready_idle_pending", 32'(pending), 32'd0);

        // T3: 20 events with no consumer; saturation and overflow
        do_reset(1);
        for (int i = 1; i <= 20; i++) begin
            flip_event();
            if (i == 15) begin
                chk("t3_pending_15",  32'(pending),  32'd15);
                chk("t3_ovf_at_15",   32'(overflow), 32'd0);
            end
            if (i == 16) begin
                chk("t3_pending_16",  32'(pending),  32'd15);
                chk("t3_ovf_at_16",   32'(overflow), 32'd1);
            end
        end
        chk("t3_count",   32'(ev_count), 32'd20);
        chk("t3_pending", 32'(pending),  32'd15);
        chk("t3_valid",   32'(ev_valid), 32'd1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("t3_ovf_cleared", 32'(overflow), 32'd0);
        chk("t3_pending_kept", 32'(pending), 32'd15);
        // Lost event on the same edge as clr_ovf: overflow must stay set
        q_in = ~q_in;
        step(2);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("t3_ovf_race", 32'(overflow), 32'd1);
        chk("t3_count_race", 32'(ev_count), 32'd21);
        step(1);

        // T4: event and accept on the same edge at pending=3
        ev_ready = 1'b1;
        step(12);
        ev_ready = 1'b0;
        chk("t4_pending_pre", 32'(pending), 32'd3);
        q_in = ~q_in;
        step(2);
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
        chk("t4_pulse",   32'(ev_pulse), 32'd1);
        chk("t4_pending", 32'(pending),  32'd3);
        chk("t4_count",   32'(ev_count), 32'd22);
        step(1);

        // T5: 258 events with ev_ready tied high; counter wraps to 2
        do_reset(1);
        ev_ready = 1'b1;
        for (int i = 0; i < 258; i++) begin
            flip_event();
        end
        ev_ready = 1'b0;
        chk("t5_count",    32'(ev_count), 32'd2);
        chk("t5_pending",  32'(pending),  32'd0);
        chk("t5_overflow", 32'(overflow), 32'd0);

        // T6: reset mid-operation with pending=5 and q_in high
        q_in = 1'b0;
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            flip_event();
        end
        chk("t6_pending_pre", 32'(pending),  32'd5);
        chk("t6_count_pre",   32'(ev_count), 32'd5);
        chk("t6_q_in_high",   32'(q_in),     32'd1);
        rs = 1'b1;
        step(1);
        rs = 1'b0;
        chk("t6_rst_pulse",    32'(ev_pulse), 32'd0);
        chk("t6_rst_valid",    32'(ev_valid), 32'd0);
        chk("t6_rst_pending",  32'(pending),  32'd0);
        chk("t6_rst_count",    32'(ev_count), 32'd0);
        chk("t6_rst_overflow", 32'(overflow), 32'd0);
        watch(20, seen);
        chk("t6_no_pulse", 32'(seen),     32'd0);
        chk("t6_count",    32'(ev_count), 32'd0);
        chk("t6_pending",  32'(pending),  32'd0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
